// File: rtl/uart_tx_sched.sv
// Round-robin arbiter over four byte producers feeding a single 8N1 UART transmitter.
// One producer is granted per frame; txd, busy and grant_id are registered.
module uart_tx_sched #(
    parameter int unsigned CLK_DIV = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    input  logic        tx_en,
    output logic        txd,
    output logic        busy,
    output logic [1:0]  grant_id
);

    localparam int unsigned CntW = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [1:0]      last_q, last_d;
    logic            txd_q, txd_d;
    logic            busy_q, busy_d;

    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    logic       grant;
    logic       bit_end;

    // First requester after the most recent grant, wrapping back to it last.
    always_comb begin
        pick  = last_q;
        idx   = last_q;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && req_valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign grant     = (state_q == StIdle) && tx_en && found && !rst;
    assign req_ready = grant ? (4'b0001 << pick) : 4'b0000;
    assign bit_end   = (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        last_d  = last_q;
        txd_d   = txd_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    shift_d = req_data[{pick, 3'b000} +: 8];
                    last_d  = pick;
                    cnt_d   = '0;
                    bit_d   = '0;
                    txd_d   = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    txd_d   = shift_q[0];
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    // txd is registered, so present the next bit as this one ends.
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = StStop;
                    end else begin
                        txd_d = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    txd_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            last_q  <= 2'd3;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

    assign txd      = txd_q;
    assign busy     = busy_q;
    assign grant_id = last_q;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler and 8N1 serializer that shares the board's single UART transmit line among four byte producers. Example producers are an echo path from the UART receiver, a status reporter and a switch/debug source. Each producer offers a byte on a valid/ready port. The block grants one producer per frame and shifts the byte out at a fixed bit period derived from the 100 MHz clock. It sits between the producer logic and the `UART_RXD_OUT` pin.

## Interface
- `CLK_DIV`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range 2..65535.
- `clk` input 1: 100 MHz system clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 4: bit i high means producer i offers `req_data[8*i+7:8*i]`.
- `req_data` input 32: four packed bytes; byte i belongs to producer i.
- `req_ready` output 4: one-hot. Bit i high for one cycle means the byte from producer i is accepted on this edge.
- `tx_en` input 1: flow-control gate; new grants only while high.
- `txd` output 1: serial line, idle high, LSB first.
- `busy` output 1: high while a frame is being shifted out.
- `grant_id` output 2: index of the most recently granted producer.

## Operation
- States: IDLE, START, DATA, STOP.
- Round-robin pointer `last` (2 bits) holds the most recent grant. Search order is `last+1`, `last+2`, `last+3`, `last`, mod 4.
- IDLE:
  - Let `g` be the first index in search order with `req_valid[g]` set.
  - If `tx_en` and `|req_valid`: `req_ready[g]`=1 combinationally in the same cycle. On that edge latch `req_data[g]` into the shift register, set `last`=`g`, clear the bit counter and cycle counter, and go to START.
  - Otherwise `req_ready`=0.
- START: `txd`=0 for `CLK_DIV` cycles, then go to DATA.
- DATA:
  - `txd`=`shift[0]`. Each bit is held for `CLK_DIV` cycles.
  - At the end of each bit, shift right and increment the bit counter (3 bits).
  - After bit 7, go to STOP.
- STOP: `txd`=1 for `CLK_DIV` cycles, then go to IDLE.
- Cycle counter width is `$clog2(CLK_DIV)`. It counts 0..`CLK_DIV`-1 and wraps to 0 at each bit boundary.
- `busy` = (state != IDLE). `grant_id` = `last`.
- `req_ready` is never asserted outside IDLE. Producers must hold `req_valid` and data stable until `req_ready`.
- `tx_en` falling mid-frame: the current frame completes unchanged. No grant is issued while it stays low.
- Changes to `req_valid` during a frame have no effect until IDLE.
- Reset, including mid-frame, takes effect immediately:
  - state=IDLE, `txd`=1, `busy`=0, `req_ready`=0.
  - `last`=3, so `grant_id`=3 and producer 0 has first priority.
  - Counters=0, shift register=0.
  - A partially sent frame is abandoned and is not retried.

## Timing
- Handshake edge E0 (IDLE, `req_ready[g]`=1).
- `txd` falls at E0+1 and stays low for `CLK_DIV` cycles.
- Data bit k is driven from E0+1+(k+1)·`CLK_DIV` for `CLK_DIV` cycles.
- Stop bit is driven from E0+1+9·`CLK_DIV`.
- IDLE is re-entered at E0+1+10·`CLK_DIV`. If a request is pending, the next handshake happens in that cycle.
- Minimum frame-to-frame period is 10·`CLK_DIV`+1 cycles.
- `busy` rises at E0+1 and falls on IDLE re-entry.
- `txd`, `busy` and `grant_id` are registered. `req_ready` is a combinational function of state, `tx_en`, `req_valid` and `last`.

## Test plan
All tests use `CLK_DIV`=4.
- **Reset values:** assert `rst` -> `txd`=1, `busy`=0, `req_ready`=0, `grant_id`=3.
- **Single frame:** `req_valid`=0001, byte0=0xA5 -> `req_ready`=0001 for one cycle. `txd` sequence, 4 cycles each: 0,1,0,1,0,0,1,0,1,1. `busy` high for 40 cycles.
- **Round-robin:** all four valid, bytes 0x10/0x21/0x32/0x43, producers drop valid after their grant -> grants in order 0,1,2,3, one frame every 41 cycles, `grant_id` follows. Then with `last`=1 and valid=1011 -> next grant is 3, then 0.
- **Flow control:** `tx_en` dropped at cycle 10 of a frame -> frame still completes 40 cycles. No `req_ready` until `tx_en` returns; grant occurs in the first cycle after it does.
- **Mid-frame reset:** `rst` pulsed during DATA bit 3 -> `txd`=1 at once. After release, the pending request from producer 0 gets a fresh full frame and `grant_id` = 0.
- **Stability:** `req_valid` toggled during a frame -> no `req_ready` pulse and the shifted byte is unchanged.
